// File: rtl/key_step_gen.sv
// Up/down push-button front end for the setting counters: sync, debounce,
// one step per press plus auto-repeat while a key is held.
module key_step_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          lvl_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The level moves only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = lvl_q;

endmodule

module key_step_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 32,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_up,
  input  logic key_down,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic up_level,
  output logic down_level,
  output logic repeating
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } state_e;

  state_e        state_q;
  logic          dir_q;
  logic [TW-1:0] timer_q;
  logic          inc_q;
  logic          dec_q;
  logic          rep_q;

  logic          up_lvl;
  logic          dn_lvl;
  logic          own_lvl;
  logic          oth_lvl;
  logic [TW-1:0] last;

  key_step_db #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (key_up),
    .level (up_lvl)
  );

  key_step_db #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (key_down),
    .level (dn_lvl)
  );

  // dir_q: 0 = up/increment, 1 = down/decrement
  assign own_lvl = dir_q ? dn_lvl : up_lvl;
  assign oth_lvl = dir_q ? up_lvl : dn_lvl;
  assign last    = (state_q == HOLD) ? HOLD_LAST : REP_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      timer_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      rep_q <= (state_q == REPEAT);
      if (!en) begin
        state_q <= (up_lvl | dn_lvl) ? LOCK : IDLE;
        timer_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            timer_q <= '0;
            if (up_lvl & dn_lvl) begin
              state_q <= LOCK;
            end else if (up_lvl) begin
              inc_q   <= 1'b1;
              dir_q   <= 1'b0;
              state_q <= HOLD;
            end else if (dn_lvl) begin
              dec_q   <= 1'b1;
              dir_q   <= 1'b1;
              state_q <= HOLD;
            end
          end
          HOLD, REPEAT: begin
            if (oth_lvl) begin
              state_q <= LOCK;
              timer_q <= '0;
            end else if (!own_lvl) begin
              state_q <= IDLE;
              timer_q <= '0;
            end else if (timer_q == last) begin
              inc_q   <= ~dir_q;
              dec_q   <= dir_q;
              timer_q <= '0;
              state_q <= REPEAT;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          LOCK: begin
            timer_q <= '0;
            if (!up_lvl && !dn_lvl) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign inc_pulse  = inc_q;
  assign dec_pulse  = dec_q;
  assign up_level   = up_lvl;
  assign down_level = dn_lvl;
  assign repeating  = rep_q;

endmodule

// File: tb/tb_key_step_gen.sv
// Bench for key_step_gen: directed scenarios plus random key activity,
// scored cycle by cycle against an event-level reference model.
module tb_key_step_gen;

  localparam int DB   = 4;
  localparam int HOLD = 32;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic key_up = 1'b1;
  logic key_down = 1'b0;
  logic inc_pulse;
  logic dec_pulse;
  logic up_level;
  logic down_level;
  logic repeating;

  key_step_gen #(
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .key_up     (key_up),
    .key_down   (key_down),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .up_level   (up_level),
    .down_level (down_level),
    .repeating  (repeating)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic inc;
    logic dec;
    logic ul;
    logic dl;
    logic rep;
  } exp_t;

  typedef enum int {FREE, ACTIVE, LOCKED} mode_e;

  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_inc = 0;
  int   n_dec = 0;

  task automatic chk(string nm, logic a, logic b);
    n_chk++;
    if (a !== b) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, b, $time);
    end
  endtask

  task automatic chk_int(string nm, int a, int b);
    n_chk++;
    if (a != b) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, b, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit    pu[2];
  bit    pd[2];
  bit    ul_m;
  bit    dl_m;
  bit    hist_u[$];
  bit    hist_d[$];
  mode_e mode;
  bit    mdir;
  int    age;
  bit    rep_prev;

  // A level settles once the last DB synced samples all disagree with it.
  function automatic bit settle(bit q[$], bit lvl);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_step(int a);
    return (a == HOLD) || (a > HOLD && ((a - HOLD) % REP) == 0);
  endfunction

  always @(posedge clk) begin
    exp_t x;
    bit   u0, d0, own, oth, su, sd;
    x = '0;
    if (rst) begin
      pu = '{0, 0};
      pd = '{0, 0};
      ul_m = 0;
      dl_m = 0;
      hist_u.delete();
      hist_d.delete();
      mode = FREE;
      mdir = 0;
      age = 0;
      rep_prev = 0;
    end else begin
      u0 = ul_m;
      d0 = dl_m;
      x.rep = rep_prev;
      if (!en) begin
        mode = (u0 || d0) ? LOCKED : FREE;
      end else begin
        case (mode)
          FREE: begin
            if (u0 && d0) mode = LOCKED;
            else if (u0 || d0) begin
              mdir = d0;
              x.inc = u0;
              x.dec = d0;
              mode = ACTIVE;
              age = 0;
            end
          end
          ACTIVE: begin
            own = mdir ? d0 : u0;
            oth = mdir ? u0 : d0;
            if (oth) mode = LOCKED;
            else if (!own) mode = FREE;
            else begin
              age++;
              if (is_step(age)) begin
                x.inc = !mdir;
                x.dec = mdir;
              end
            end
          end
          default: if (!u0 && !d0) mode = FREE;
        endcase
      end
      rep_prev = (mode == ACTIVE) && (age >= HOLD);
      su = pu[1];
      sd = pd[1];
      pu[1] = pu[0];
      pu[0] = key_up;
      pd[1] = pd[0];
      pd[0] = key_down;
      hist_u.push_back(su);
      hist_d.push_back(sd);
      if (hist_u.size() > DB) void'(hist_u.pop_front());
      if (hist_d.size() > DB) void'(hist_d.pop_front());
      if (settle(hist_u, ul_m)) begin
        ul_m = !ul_m;
        hist_u.delete();
      end
      if (settle(hist_d, dl_m)) begin
        dl_m = !dl_m;
        hist_d.delete();
      end
      x.ul = ul_m;
      x.dl = dl_m;
    end
    expq.push_back(x);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() == 0) begin
      chk_int("scoreboard_depth", 0, 1);
    end else begin
      e = expq.pop_front();
      chk("inc_pulse", inc_pulse, e.inc);
      chk("dec_pulse", dec_pulse, e.dec);
      chk("up_level", up_level, e.ul);
      chk("down_level", down_level, e.dl);
      chk("repeating", repeating, e.rep);
      chk("pulse_exclusive", inc_pulse & dec_pulse, 1'b0);
      if (inc_pulse === 1'b1) n_inc++;
      if (dec_pulse === 1'b1) n_dec++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int first;
    int fall;
    bit u, d;
    int len;

    // reset held with key pressed, then first pulse DB+3 after release
    tick(3);
    chk("rst_inc", inc_pulse, 1'b0);
    chk("rst_level", up_level, 1'b0);
    c0 = n_inc;
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (inc_pulse && first == 0) first = i;
    end
    chk_int("rst_first_pulse", first, DB + 3);
    chk_int("rst_pulse_count", n_inc - c0, 1);
    key_up = 1'b0;
    tick(15);

    // bounce: never settles, then one pulse once stable
    c0 = n_inc;
    for (int i = 0; i < 6; i++) begin
      key_up = (i % 2 == 0);
      tick(2);
    end
    chk("bounce_level", up_level, 1'b0);
    key_up = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (inc_pulse && first == 0) first = i;
    end
    chk_int("bounce_first_pulse", first, 7);
    chk_int("bounce_pulse_count", n_inc - c0, 1);
    key_up = 1'b0;
    fall = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (!up_level && fall == 0) fall = i;
    end
    chk_int("release_latency", fall, DB + 2);
    tick(10);

    // long press: t0, +32, +40 ... +72
    c0 = n_inc;
    key_up = 1'b1;
    tick(78);
    key_up = 1'b0;
    tick(15);
    chk_int("longpress_count", n_inc - c0, 7);

    // conflict lock
    key_up = 1'b1;
    tick(50);
    key_down = 1'b1;
    tick(10);
    c0 = n_inc + n_dec;
    tick(10);
    key_down = 1'b0;
    tick(20);
    chk_int("lock_no_pulses", n_inc + n_dec - c0, 0);
    key_up = 1'b0;
    tick(15);
    c0 = n_dec;
    key_down = 1'b1;
    tick(20);
    key_down = 1'b0;
    tick(15);
    chk_int("after_lock_dec", n_dec - c0, 1);

    // enable drop during repeat
    key_up = 1'b1;
    tick(50);
    c0 = n_inc;
    en = 1'b0;
    tick(10);
    en = 1'b1;
    tick(30);
    key_up = 1'b0;
    tick(15);
    chk_int("en_drop_no_pulses", n_inc - c0, 0);
    c0 = n_inc;
    key_up = 1'b1;
    tick(20);
    key_up = 1'b0;
    tick(15);
    chk_int("en_repress_pulse", n_inc - c0, 1);

    // reset in the middle of a hold
    key_up = 1'b1;
    tick(27);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (inc_pulse && first == 0) first = i;
    end
    chk_int("midrst_first_pulse", first, DB + 3);
    tick(10);
    key_up = 1'b0;
    tick(15);

    // random activity
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      u = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 3) == 0);
      key_up = u;
      key_down = d;
      en = ($urandom_range(0, 9) != 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                         : $urandom_range(5, 90);
      tick(len);
    end
    key_up = 1'b0;
    key_down = 1'b0;
    en = 1'b1;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
